// File: rtl/spart_driver.sv
// Echo driver for a SPART: programs the baud divisor, then polls for RX bytes and writes them back.
// Latency: 4 clk minimum from rda sampled high to the echo write; reconfiguration costs 2 clk.
// Backpressure: holds in POLL_TX while tbr=0. SPART_DRIVER_CASE_FLIP_EN echoes a-z as A-Z.
module spart_driver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr,
    output logic [7:0] echo_cnt,
    output logic [7:0] last_rx
);

    typedef enum logic [2:0] {
        CFG_LO   = 3'd0,
        CFG_HI   = 3'd1,
        POLL_RX  = 3'd2,
        READ_RX  = 3'd3,
        POLL_TX  = 3'd4,
        WRITE_TX = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  br_cfg_q;
    logic [1:0]  cfg_act;
    logic [15:0] divisor;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_dat;
    logic [7:0]  bus_out;
    logic        bus_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cfg_q <= br_cfg;
        end else begin
            br_cfg_q <= br_cfg;
        end
    end

    always_comb begin
        divisor = 16'h028C;
        case (br_cfg_q)
            2'b00:   divisor = 16'h028C;
            2'b01:   divisor = 16'h0145;
            2'b10:   divisor = 16'h00A3;
            default: divisor = 16'h0052;
        endcase
    end

`ifdef SPART_DRIVER_CASE_FLIP_EN
    assign tx_dat = (rx_byte >= 8'h61 && rx_byte <= 8'h7A) ? (rx_byte & 8'hDF) : rx_byte;
`else
    assign tx_dat = rx_byte;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CFG_LO;
        end else begin
            state <= state_nxt;
        end
    end

    // cfg_act remembers which setting was last programmed, so a br_cfg_q change
    // seen during an echo is still acted on once the FSM is back in POLL_RX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_act  <= br_cfg;
            rx_byte  <= 8'h00;
            last_rx  <= 8'h00;
            echo_cnt <= 8'h00;
        end else begin
            if (state == CFG_LO) begin
                cfg_act <= br_cfg_q;
            end
            if (state == READ_RX) begin
                rx_byte <= databus;
                last_rx <= databus;
            end
            if (state == WRITE_TX) begin
                echo_cnt <= echo_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        iocs      = 1'b1;
        iorw      = 1'b1;
        ioaddr    = 2'b01;
        bus_out   = 8'h00;
        bus_en    = 1'b0;
        case (state)
            CFG_LO: begin
                iorw      = 1'b0;
                ioaddr    = 2'b10;
                bus_out   = divisor[7:0];
                bus_en    = 1'b1;
                state_nxt = CFG_HI;
            end
            CFG_HI: begin
                iorw      = 1'b0;
                ioaddr    = 2'b11;
                bus_out   = divisor[15:8];
                bus_en    = 1'b1;
                state_nxt = POLL_RX;
            end
            POLL_RX: begin
                if (rda) begin
                    state_nxt = READ_RX;
                end else if (br_cfg_q != cfg_act) begin
                    state_nxt = CFG_LO;
                end
            end
            READ_RX: begin
                ioaddr    = 2'b00;
                state_nxt = POLL_TX;
            end
            POLL_TX: begin
                if (tbr) begin
                    state_nxt = WRITE_TX;
                end
            end
            WRITE_TX: begin
                iorw      = 1'b0;
                ioaddr    = 2'b00;
                bus_out   = tx_dat;
                bus_en    = 1'b1;
                state_nxt = POLL_RX;
            end
            default: state_nxt = CFG_LO;
        endcase
        // The bus and chip select are released for the whole reset interval.
        if (!rst_n) begin
            iocs   = 1'b0;
            bus_en = 1'b0;
        end
    end

    assign databus = bus_en ? bus_out : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: directed divisor/echo sequences plus a random run
// against a transaction-level model of the SPART bus protocol.
`timescale 1ns/1ps
module tb_spart_driver;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [1:0] br_cfg = 2'b00;
    logic       rda    = 1'b0;
    logic       tbr    = 1'b0;
    logic [7:0] tb_dat = 8'h00;

    wire        iocs;
    wire        iorw;
    wire [1:0]  ioaddr;
    wire [7:0]  databus;
    wire [7:0]  echo_cnt;
    wire [7:0]  last_rx;

    // The SPART side drives the bus whenever the driver must not.
    wire tb_drv = !(iocs && !iorw);
    assign databus = tb_drv ? tb_dat : 8'hzz;

    spart_driver dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .br_cfg   (br_cfg),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .rda      (rda),
        .tbr      (tbr),
        .echo_cnt (echo_cnt),
        .last_rx  (last_rx)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] cfg;
        logic [7:0] lo;
        logic [7:0] hi;
    } cfg_vec_t;
    cfg_vec_t vt [4];

    logic [7:0] d_cnt;

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic logic [7:0] flip(input logic [7:0] b);
`ifdef SPART_DRIVER_CASE_FLIP_EN
        return (b >= 8'h61 && b <= 8'h7A) ? (b & 8'hDF) : b;
`else
        return b;
`endif
    endfunction

    // ---------------- protocol-level reference model ----------------
    localparam int K_LO = 0, K_HI = 1, K_RXP = 2, K_RD = 3, K_TXP = 4, K_WR = 5, K_BAD = 6;

    logic [1:0] br_q_m;
    always @(posedge clk or negedge rst_n) br_q_m <= br_cfg;

    int         exp_k = K_LO;
    int         k;
    logic       m_pend = 1'b0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_cnt  = 8'h00;
    logic [1:0] m_act  = 2'b00;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("mon_rst_iocs", 16'(iocs), 16'd0);
            chk("mon_rst_bus", 16'(databus), 16'(tb_dat));
            m_pend = 1'b0;
            m_cnt  = 8'h00;
            m_last = 8'h00;
            exp_k  = K_LO;
        end else begin
            chk("mon_echo_cnt", 16'(echo_cnt), 16'(m_cnt));
            chk("mon_last_rx", 16'(last_rx), 16'(m_last));
            k = K_BAD;
            if (iocs && !iorw) begin
                case (ioaddr)
                    2'b10:   k = K_LO;
                    2'b11:   k = K_HI;
                    2'b00:   k = K_WR;
                    default: k = K_BAD;
                endcase
            end else if (iocs && iorw) begin
                case (ioaddr)
                    2'b01:   k = m_pend ? K_TXP : K_RXP;
                    2'b00:   k = K_RD;
                    default: k = K_BAD;
                endcase
                chk("mon_bus_hiz", 16'(databus), 16'(tb_dat));
            end
            chk("mon_state", 16'(k), 16'(exp_k));
            case (k)
                K_LO: begin
                    chk("mon_div_lo", 16'(databus), 16'(vt[br_q_m].lo));
                    m_act = br_q_m;
                    exp_k = K_HI;
                end
                K_HI: begin
                    chk("mon_div_hi", 16'(databus), 16'(vt[br_q_m].hi));
                    exp_k = K_RXP;
                end
                K_RXP: exp_k = rda ? K_RD : ((br_q_m != m_act) ? K_LO : K_RXP);
                K_RD: begin
                    m_pend = 1'b1;
                    m_byte = databus;
                    m_last = databus;
                    exp_k  = K_TXP;
                end
                K_TXP: exp_k = tbr ? K_WR : K_TXP;
                K_WR: begin
                    chk("mon_echo_dat", 16'(databus), 16'(flip(m_byte)));
                    m_pend = 1'b0;
                    m_cnt  = m_cnt + 8'd1;
                    exp_k  = K_RXP;
                end
                default: exp_k = K_LO;
            endcase
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] c);
        rda    = 1'b0;
        tbr    = 1'b0;
        rst_n  = 1'b0;
        br_cfg = c;
        d_cnt  = 8'h00;
        #1;
        chk("rst_iocs", 16'(iocs), 16'd0);
        tick();
        chk("rst_echo_cnt", 16'(echo_cnt), 16'd0);
        chk("rst_last_rx", 16'(last_rx), 16'd0);
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic expect_cyc(input string nm, input logic rw, input logic [1:0] a, input logic [7:0] d);
        chk({nm, "_iocs"}, 16'(iocs), 16'd1);
        chk({nm, "_iorw"}, 16'(iorw), 16'(rw));
        chk({nm, "_addr"}, 16'(ioaddr), 16'(a));
        if (!rw) chk({nm, "_data"}, 16'(databus), 16'(d));
        else     chk({nm, "_hiz"}, 16'(databus), 16'(tb_dat));
    endtask

    task automatic check_cfg(input int i);
        expect_cyc("cfg_lo", 1'b0, 2'b10, vt[i].lo);
        tick();
        expect_cyc("cfg_hi", 1'b0, 2'b11, vt[i].hi);
        tick();
        expect_cyc("cfg_poll", 1'b1, 2'b01, 8'h00);
    endtask

    // Call while in POLL_RX; d = cycles tbr is held low in POLL_TX.
    task automatic echo_one(input logic [7:0] b, input logic [7:0] want, input int d, input string nm);
        rda    = 1'b1;
        tb_dat = b;
        tick();
        expect_cyc({nm, "_rd"}, 1'b1, 2'b00, 8'h00);
        rda = 1'b0;
        tick();
        chk({nm, "_last_rx"}, 16'(last_rx), 16'(b));
        for (int i = 0; i < d; i++) begin
            expect_cyc({nm, "_wait"}, 1'b1, 2'b01, 8'h00);
            tick();
        end
        tbr = 1'b1;
        expect_cyc({nm, "_ptx"}, 1'b1, 2'b01, 8'h00);
        tick();
        expect_cyc({nm, "_wr"}, 1'b0, 2'b00, want);
        tbr = 1'b0;
        tick();
        d_cnt = d_cnt + 8'd1;
        chk({nm, "_cnt"}, 16'(echo_cnt), 16'(d_cnt));
        expect_cyc({nm, "_prx"}, 1'b1, 2'b01, 8'h00);
    endtask

    initial begin
        vt[0] = '{2'b00, 8'h8C, 8'h02};
        vt[1] = '{2'b01, 8'h45, 8'h01};
        vt[2] = '{2'b10, 8'hA3, 8'h00};
        vt[3] = '{2'b11, 8'h52, 8'h00};

        // Divisor programming right after reset, every baud setting.
        for (int i = 0; i < 4; i++) begin
            do_reset(vt[i].cfg);
            check_cfg(i);
            tick();
        end

        // Single echo at minimum latency, then case handling and tbr stall.
        do_reset(2'b01);
        check_cfg(1);
        echo_one(8'h41, 8'h41, 0, "echo41");
        chk("echo41_last", 16'(last_rx), 16'h0041);
`ifdef SPART_DRIVER_CASE_FLIP_EN
        echo_one(8'h61, 8'h41, 0, "echo61");
`else
        echo_one(8'h61, 8'h61, 0, "echo61");
`endif
        chk("echo61_last", 16'(last_rx), 16'h0061);
        echo_one(8'h7B, 8'h7B, 20, "stall");

        // Baud change during POLL_TX: echo finishes, then reprogram to 38400.
        rda    = 1'b1;
        tb_dat = 8'h33;
        tick();
        expect_cyc("bchg_rd", 1'b1, 2'b00, 8'h00);
        rda    = 1'b0;
        br_cfg = 2'b11;
        tick();
        expect_cyc("bchg_ptx0", 1'b1, 2'b01, 8'h00);
        tick();
        expect_cyc("bchg_ptx1", 1'b1, 2'b01, 8'h00);
        tbr = 1'b1;
        tick();
        expect_cyc("bchg_wr", 1'b0, 2'b00, 8'h33);
        tbr = 1'b0;
        tick();
        expect_cyc("bchg_prx", 1'b1, 2'b01, 8'h00);
        tick();
        expect_cyc("bchg_lo", 1'b0, 2'b10, 8'h52);
        tick();
        expect_cyc("bchg_hi", 1'b0, 2'b11, 8'h00);
        tick();
        expect_cyc("bchg_poll", 1'b1, 2'b01, 8'h00);

        // 256 echoes wrap the counter back to zero.
        do_reset(2'b10);
        check_cfg(2);
        for (int i = 0; i < 256; i++) begin
            echo_one(8'(i), flip(8'(i)), 0, "wrap");
        end
        chk("wrap_zero", 16'(echo_cnt), 16'h0000);

        // Reset pulse while waiting for tbr drops the pending byte.
        do_reset(2'b00);
        check_cfg(0);
        echo_one(8'h10, 8'h10, 0, "pre");
        rda    = 1'b1;
        tb_dat = 8'h77;
        tick();
        expect_cyc("rst_rd", 1'b1, 2'b00, 8'h00);
        rda = 1'b0;
        tick();
        expect_cyc("rst_ptx", 1'b1, 2'b01, 8'h00);
        rst_n = 1'b0;
        tbr   = 1'b1;
        #1;
        chk("midrst_iocs", 16'(iocs), 16'd0);
        chk("midrst_cnt", 16'(echo_cnt), 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        d_cnt = 8'h00;
        #1;
        check_cfg(0);
        chk("midrst_cnt_after", 16'(echo_cnt), 16'd0);
        chk("midrst_last_after", 16'(last_rx), 16'd0);
        tbr = 1'b0;
        tick();

        // Random traffic; the protocol model checks every cycle.
        do_reset(2'($urandom_range(0, 3)));
        for (int n = 0; n < 4000; n++) begin
            rda    = ($urandom_range(0, 3) == 0);
            tbr    = ($urandom_range(0, 2) == 0);
            tb_dat = 8'($urandom);
            if ($urandom_range(0, 60) == 0) br_cfg = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 700) == 0) begin
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spart_driver.md
SPART_DRIVER -- requirements
Module: spart_driver

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, 50 MHz system clock.
REQ-002 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-003 The block SHALL have port br_cfg, input, 2 bits, baud select (00=4800, 01=9600, 10=19200, 11=38400).
REQ-004 The block SHALL have port iocs, output, 1 bit, SPART chip select, active-high.
REQ-005 The block SHALL have port iorw, output, 1 bit, access direction: 1=read (SPART->driver), 0=write (driver->SPART).
REQ-006 The block SHALL have port ioaddr, output, 2 bits, register select: 00=TX/RX buffer, 01=status, 10=divisor low, 11=divisor high.
REQ-007 The block SHALL have port databus, inout, 8 bits, shared data bus; driven by this block only when iocs=1 and iorw=0, otherwise high-Z.
REQ-008 The block SHALL have port rda, input, 1 bit, receive data available.
REQ-009 The block SHALL have port tbr, input, 1 bit, transmit buffer ready.
REQ-010 The block SHALL have port echo_cnt, output, 8 bits, count of bytes echoed.
REQ-011 The block SHALL have port last_rx, output, 8 bits, most recently received byte.

Function
REQ-012 The divisor SHALL be taken from br_cfg: 00->16'h028C, 01->16'h0145, 10->16'h00A3, 11->16'h0052.
REQ-013 The FSM SHALL have states CFG_LO, CFG_HI, POLL_RX, READ_RX, POLL_TX, WRITE_TX; each state lasts at least one clk.
REQ-014 In CFG_LO the block SHALL drive iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0], then go to CFG_HI.
REQ-015 In CFG_HI the block SHALL drive iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8], then go to POLL_RX.
REQ-016 In POLL_RX the block SHALL drive iocs=1, iorw=1, ioaddr=01 and sample rda each clk; rda=1 -> READ_RX.
REQ-017 In READ_RX the block SHALL drive iocs=1, iorw=1, ioaddr=00, capture databus into the byte register at the closing clk edge, update last_rx on that same edge, then go to POLL_TX.
REQ-018 In POLL_TX the block SHALL drive iocs=1, iorw=1, ioaddr=01 and sample tbr each clk; tbr=1 -> WRITE_TX.
REQ-019 In WRITE_TX the block SHALL drive iocs=1, iorw=0, ioaddr=00, databus=byte register, increment echo_cnt, then go to POLL_RX.
REQ-020 echo_cnt SHALL wrap from 8'hFF to 8'h00.
REQ-021 br_cfg SHALL be registered once per clk into br_cfg_q; the divisor SHALL use br_cfg_q only.
REQ-022 A change of br_cfg_q while the FSM is in POLL_RX with rda=0 SHALL send the FSM to CFG_LO.
REQ-023 A change of br_cfg_q while in POLL_RX with rda=1 in the same clk SHALL go to READ_RX; the read takes priority over reconfiguration.
REQ-024 A change of br_cfg_q in READ_RX, POLL_TX or WRITE_TX SHALL be deferred until the FSM next enters POLL_RX; the echo in progress completes.
REQ-025 Minimum echo latency SHALL be 4 clk: rda=1 first sampled -> READ_RX -> POLL_TX (tbr=1) -> WRITE_TX.
REQ-026 databus SHALL never be driven by this block in any cycle where iorw=1.

Reset
REQ-027 On rst_n=0 the FSM SHALL enter CFG_LO immediately.
REQ-028 On rst_n=0, echo_cnt, last_rx and the byte register SHALL be 8'h00.
REQ-029 On rst_n=0, br_cfg_q SHALL load br_cfg.
REQ-030 While rst_n=0, iocs SHALL be 0 and databus SHALL be high-Z.
REQ-031 Reset asserted mid-echo SHALL drop the pending byte without writing it.
REQ-032 The first clk after rst_n deasserts SHALL be a CFG_LO write.

Configuration
REQ-033 With SPART_DRIVER_CASE_FLIP_EN defined, a received byte in 8'h61-8'h7A SHALL be echoed with bit 5 cleared (lowercase->uppercase), and last_rx SHALL hold the unmodified byte.
REQ-034 Without SPART_DRIVER_CASE_FLIP_EN, every byte SHALL be echoed unmodified and the flip logic SHALL be absent.

Verification
REQ-035 Reset release with br_cfg=01 -> databus writes 8'h45 at ioaddr=10, then 8'h01 at ioaddr=11, on consecutive clks.
REQ-036 rda=1 with SPART driving 8'h41, tbr=1 -> WRITE_TX drives 8'h41 at ioaddr=00 four clks after rda is first sampled; echo_cnt=1; last_rx=8'h41.
REQ-037 Byte 8'h61 with macro defined -> echo 8'h41; without the macro -> echo 8'h61; last_rx=8'h61 in both cases.
REQ-038 tbr held 0 for 20 clks after READ_RX -> FSM stays in POLL_TX with databus high-Z; tbr=1 -> one write.
REQ-039 br_cfg 01->11 during POLL_TX -> echo completes first, then writes 8'h52 and 8'h00 to the divisor registers; 256 echoes -> echo_cnt returns to 8'h00.
REQ-040 rst_n pulsed low during POLL_TX -> no TX write occurs, echo_cnt=0, and the FSM restarts at CFG_LO.
